// File: rtl/decompressor_top.sv
// decompressor_top: LZRW1-style decompressor core.
// Takes one 16-bit item per handshake (literal or copy) and emits the
// decompressed stream one byte per clock, recording every emitted byte in a
// circular history buffer so copy items can be expanded from it.
// Optional feature macro: DECOMP_OFFSET_CHECK_EN -- when defined, copies with
// offset 0 or offset > HISTORY_SIZE emit 0x00 bytes (timing and history
// updates unchanged).
module decompressor_top #(
  parameter int HISTORY_SIZE = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        control_word_in,
  input  logic        data_in_valid,
  output logic [7:0]  decompressed_byte,
  output logic        out_valid,
  output logic        decompressor_busy
);

  localparam int AW = $clog2(HISTORY_SIZE);

  typedef enum logic {IDLE, EMIT} state_t;

  // Decoded view of the incoming item.
  typedef struct packed {
    logic        is_copy;
    logic [3:0]  len_m3;
    logic [11:0] offset;
  } item_t;

  item_t         in_item;
  state_t        state;
  logic [4:0]    remain;      // bytes still to emit after the one on the output
  logic [AW-1:0] off_q;
  logic          illegal_q;
  logic [AW-1:0] wr_ptr;
  logic          wrapped;     // wr_ptr has passed the top once: every slot written
  logic [7:0]    hist [HISTORY_SIZE];

  logic          accept;
  logic          more;
  logic          emit;
  logic          in_illegal;
  logic          cur_illegal;
  logic [AW-1:0] cur_off;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    next_byte;

  assign in_item = '{is_copy: control_word_in,
                     len_m3:  data_in[15:12],
                     offset:  data_in[11:0]};

`ifdef DECOMP_OFFSET_CHECK_EN
  assign in_illegal = in_item.is_copy &&
                      ((in_item.offset == 12'd0) ||
                       ({1'b0, in_item.offset} > 13'(HISTORY_SIZE)));
`else
  assign in_illegal = 1'b0;
`endif

  assign accept      = (state == IDLE) && data_in_valid;
  assign more        = (state == EMIT) && (remain != 5'd0);
  assign emit        = accept || more;
  assign cur_off     = accept ? in_item.offset[AW-1:0] : off_q;
  assign cur_illegal = accept ? in_illegal : illegal_q;
  assign rd_addr     = wr_ptr - cur_off;

  // Asynchronous read so a distance-1 copy sees the byte written last edge.
  // Slots never written since reset read as zero instead of clearing the RAM.
  always_comb begin
    rd_data = 8'h00;
    if (wrapped || (rd_addr < wr_ptr)) rd_data = hist[rd_addr];
  end

  // Select the byte presented next: literal payload, zero for illegal copies,
  // otherwise the history byte at the copy distance.
  always_comb begin
    next_byte = rd_data;
    if (accept && !in_item.is_copy) next_byte = data_in[7:0];
    else if (cur_illegal)           next_byte = 8'h00;
  end

  // History RAM: each emitted byte is stored at the current write pointer.
  always_ff @(posedge clock) begin
    if (emit) hist[wr_ptr] <= next_byte;
  end

  // Control FSM, write pointer and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      remain            <= '0;
      off_q             <= '0;
      illegal_q         <= 1'b0;
      wr_ptr            <= '0;
      wrapped           <= 1'b0;
      decompressed_byte <= 8'h00;
      out_valid         <= 1'b0;
      decompressor_busy <= 1'b0;
    end else begin
      if (emit) begin
        decompressed_byte <= next_byte;
        wr_ptr            <= wr_ptr + 1'b1;
        if (wr_ptr == {AW{1'b1}}) wrapped <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state             <= EMIT;
            out_valid         <= 1'b1;
            decompressor_busy <= 1'b1;
            off_q             <= in_item.offset[AW-1:0];
            illegal_q         <= in_illegal;
            remain            <= in_item.is_copy ? ({1'b0, in_item.len_m3} + 5'd2) : 5'd0;
          end
        end
        EMIT: begin
          if (remain == 5'd0) begin
            state             <= IDLE;
            out_valid         <= 1'b0;
            decompressor_busy <= 1'b0;
          end else begin
            remain <= remain - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decompressor_top.sv
// Directed testbench for decompressor_top (HISTORY_SIZE = 256 so the
// wrap-around case stays short).
module tb_decompressor_top;

  localparam int HS = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = 16'h0000;
  logic        control_word_in = 1'b0;
  logic        data_in_valid = 1'b0;
  logic [7:0]  decompressed_byte;
  logic        out_valid;
  logic        decompressor_busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] cap [0:63];
  int         cap_n;
  bit         cap_split;

  decompressor_top #(.HISTORY_SIZE(HS)) dut (
    .clock(clock),
    .reset(reset),
    .data_in(data_in),
    .control_word_in(control_word_in),
    .data_in_valid(data_in_valid),
    .decompressed_byte(decompressed_byte),
    .out_valid(out_valid),
    .decompressor_busy(decompressor_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called #1 after an edge in IDLE. Presents one item, then captures the
  // bytes of the consecutive out_valid run. Returns #1 after the first idle edge.
  task automatic run_item(input logic [15:0] d, input logic cw);
    data_in = d; control_word_in = cw; data_in_valid = 1'b1;
    @(posedge clock); #1;
    data_in_valid = 1'b0; data_in = 16'hDEAD; control_word_in = ~cw;
    cap_n = 0; cap_split = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== decompressor_busy) cap_split = 1;
      if (out_valid !== 1'b1) break;
      cap[cap_n] = decompressed_byte;
      cap_n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, decompressor_busy, decompressed_byte} !== 10'h000) begin
      failures++;
      $display("FAIL reset_async: got ov=%b busy=%b byte=%h exp 0 0 00", out_valid, decompressor_busy, decompressed_byte);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({out_valid, decompressor_busy, decompressed_byte} !== 10'h000) begin
      failures++;
      $display("FAIL reset_idle: got ov=%b busy=%b byte=%h exp 0 0 00", out_valid, decompressor_busy, decompressed_byte);
    end
  endtask

  task automatic test_literal();
    run_item(16'h0041, 1'b0);
    checks++;
    if (cap_n !== 1 || cap_split) begin
      failures++;
      $display("FAIL literal_len: got %0d cycles split=%0d exp 1 cycle split=0", cap_n, cap_split);
    end
    checks++;
    if (cap[0] !== 8'h41) begin
      failures++;
      $display("FAIL literal_byte: got %h exp 41", cap[0]);
    end
  endtask

  task automatic test_copy();
    run_item(16'h0061, 1'b0);
    run_item(16'h0062, 1'b0);
    run_item(16'h0063, 1'b0);
    run_item(16'h0003, 1'b1);
    checks++;
    if (cap_n !== 3 || cap_split) begin
      failures++;
      $display("FAIL copy_len: got %0d cycles split=%0d exp 3", cap_n, cap_split);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cap[k] !== 8'(8'h61 + k)) begin
        failures++;
        $display("FAIL copy_byte%0d: got %h exp %h", k, cap[k], 8'(8'h61 + k));
      end
    end
  endtask

  task automatic test_overlap();
    run_item(16'h0078, 1'b0);
    run_item(16'h2001, 1'b1);
    checks++;
    if (cap_n !== 5 || cap_split) begin
      failures++;
      $display("FAIL overlap_len: got %0d cycles split=%0d exp 5", cap_n, cap_split);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cap[k] !== 8'h78) begin
        failures++;
        $display("FAIL overlap_byte%0d: got %h exp 78", k, cap[k]);
      end
    end
  endtask

  task automatic test_max_len();
    logic [7:0] w4 [0:3];
    w4[0] = 8'h77; w4[1] = 8'h78; w4[2] = 8'h79; w4[3] = 8'h7a;
    for (int i = 0; i < 4; i++) run_item({8'h00, w4[i]}, 1'b0);
    run_item(16'hF004, 1'b1);
    checks++;
    if (cap_n !== 18 || cap_split) begin
      failures++;
      $display("FAIL maxlen_len: got %0d cycles split=%0d exp 18", cap_n, cap_split);
    end
    for (int k = 0; k < 18; k++) begin
      checks++;
      if (cap[k] !== w4[k % 4]) begin
        failures++;
        $display("FAIL maxlen_byte%0d: got %h exp %h", k, cap[k], w4[k % 4]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    run_item(16'h0031, 1'b0);
    run_item(16'h0032, 1'b0);
    run_item(16'h0033, 1'b0);
    data_in = 16'h0003; control_word_in = 1'b1; data_in_valid = 1'b1;
    @(posedge clock); #1;
    // Different item held valid (and data_in changed) for the whole copy.
    data_in = 16'h0055; control_word_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || decompressor_busy !== 1'b1 || decompressed_byte !== 8'(8'h31 + k)) begin
        failures++;
        $display("FAIL ignore_byte%0d: got ov=%b busy=%b byte=%h exp 1 1 %h", k, out_valid, decompressor_busy, decompressed_byte, 8'(8'h31 + k));
      end
      if (k == 2) data_in_valid = 1'b0;
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0 || decompressor_busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_idle: got ov=%b busy=%b exp 0 0", out_valid, decompressor_busy);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      run_item({8'h00, 8'(i * 7 + 3)}, 1'b0);
      if (cap_n != 1 || cap[0] !== 8'(i * 7 + 3)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wrap_fill: got %0d bad literals exp 0", bad);
    end
    run_item(16'h0100, 1'b1);
    checks++;
    if (cap_n !== 3) begin
      failures++;
      $display("FAIL wrap_len: got %0d cycles exp 3", cap_n);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cap[k] !== 8'((44 + k) * 7 + 3)) begin
        failures++;
        $display("FAIL wrap_byte%0d: got %h exp %h", k, cap[k], 8'((44 + k) * 7 + 3));
      end
    end
  endtask

  task automatic test_reset_mid();
    data_in = 16'h7001; control_word_in = 1'b1; data_in_valid = 1'b1;
    @(posedge clock); #1;
    data_in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, decompressor_busy, decompressed_byte} !== 10'h000) begin
      failures++;
      $display("FAIL midreset: got ov=%b busy=%b byte=%h exp 0 0 00", out_valid, decompressor_busy, decompressed_byte);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0 || decompressor_busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_after: got ov=%b busy=%b exp 0 0", out_valid, decompressor_busy);
    end
    run_item(16'h005A, 1'b0);
    checks++;
    if (cap_n !== 1 || cap[0] !== 8'h5A) begin
      failures++;
      $display("FAIL postreset_lit: got n=%0d byte=%h exp n=1 5a", cap_n, cap[0]);
    end
    run_item(16'h0001, 1'b1);
    checks++;
    if (cap_n !== 3 || cap[0] !== 8'h5A || cap[1] !== 8'h5A || cap[2] !== 8'h5A) begin
      failures++;
      $display("FAIL postreset_copy: got n=%0d %h %h %h exp 3 5a 5a 5a", cap_n, cap[0], cap[1], cap[2]);
    end
    // Reaches slots not written since reset.
    run_item(16'h000A, 1'b1);
    checks++;
    if (cap_n !== 3 || cap[0] !== 8'h00 || cap[1] !== 8'h00 || cap[2] !== 8'h00) begin
      failures++;
      $display("FAIL unwritten_copy: got n=%0d %h %h %h exp 3 00 00 00", cap_n, cap[0], cap[1], cap[2]);
    end
  endtask

  initial begin
    test_reset();
    test_literal();
    test_copy();
    test_overlap();
    test_max_len();
    test_busy_ignore();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
